// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a two-input gate block: sweeps {a,b}, checks eight gate outputs.
// Optional fault injection on the expected NAND bit is enabled with GATE_BIST_FAULT_INJ_EN.
module gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef GATE_BIST_FAULT_INJ_EN
  input  logic       fault_inj,
`endif
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] err_count,
  output logic [1:0] fail_vec
);

  // state  | meaning
  // IDLE   | waiting for start, a/b parked at 0
  // DRIVE  | load {a,b} with the current vector
  // SETTLE | down-count SETTLE_CYCLES while the gate settles
  // CHECK  | compare y_in against the expected truth row
  // DONE   | one-cycle done pulse, pass latched
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [7:0] LAST_ROUND  = 8'(ROUNDS - 1);

  logic [2:0] r_state;
  logic [1:0] r_vec;
  logic [7:0] r_round;
  logic [3:0] r_settle_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_pass;
  logic [7:0] r_fail_mask;
  logic [3:0] r_err_count;
  logic [1:0] r_fail_vec;

  logic [7:0] w_exp;
  logic [7:0] w_exp_chk;
  logic [7:0] w_mis;
  logic       w_any_mis;
  logic [3:0] w_err_nxt;

  // Bit order: XNOR, XOR, NOR, OR, AND, NAND, NOT b, NOT a
  assign w_exp = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), r_a | r_b,
                  r_a & r_b, ~(r_a & r_b), ~r_b, ~r_a};

`ifdef GATE_BIST_FAULT_INJ_EN
  assign w_exp_chk = w_exp ^ {5'b00000, fault_inj, 2'b00};
`else
  assign w_exp_chk = w_exp;
`endif

  assign w_mis     = y_in ^ w_exp_chk;
  assign w_any_mis = |w_mis;
  assign w_err_nxt = (w_any_mis && (r_err_count != 4'hF)) ? r_err_count + 4'd1 : r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 2'd0;
      r_round      <= 8'd0;
      r_settle_cnt <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_mask  <= 8'd0;
      r_err_count  <= 4'd0;
      r_fail_vec   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_DRIVE;
            r_vec       <= 2'd0;
            r_round     <= 8'd0;
            r_pass      <= 1'b0;
            r_fail_mask <= 8'd0;
            r_err_count <= 4'd0;
            r_fail_vec  <= 2'd0;
          end
        end
        S_DRIVE: begin
          r_a <= r_vec[1];
          r_b <= r_vec[0];
          if (SETTLE_CYCLES > 0) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          r_fail_mask <= r_fail_mask | w_mis;
          r_err_count <= w_err_nxt;
          // err_count never returns to zero inside a run, so zero marks the first mismatch
          if (w_any_mis && (r_err_count == 4'd0)) begin
            r_fail_vec <= {r_a, r_b};
          end
          if (r_vec == 2'd3) begin
            r_vec <= 2'd0;
            if (r_round == LAST_ROUND) begin
              r_state <= S_DONE;
              r_a     <= 1'b0;
              r_b     <= 1'b0;
              r_pass  <= (w_err_nxt == 4'd0);
            end else begin
              r_round <= r_round + 8'd1;
              r_state <= S_DRIVE;
            end
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: default instance plus a ROUNDS=5, SETTLE_CYCLES=0 instance.
module tb_gate_bist_ctrl;

  typedef struct {
    logic       pass;
    logic [7:0] mask;
    logic [3:0] err;
    logic [1:0] fv;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic fi0 = 1'b0;
  logic fi1 = 1'b0;
  int   mode0 = 0;

  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] y0, mask0;
  logic [3:0] err0;
  logic [1:0] fv0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] y1, mask1;
  logic [3:0] err1;
  logic [1:0] fv1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc0 = 0;
  int cyc1 = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [1:0] qab[$];

  always #5 clk = ~clk;

  gate_bist_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef GATE_BIST_FAULT_INJ_EN
    .fault_inj(fi0),
`endif
    .start(start0), .a(a0), .b(b0), .y_in(y0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_mask(mask0), .err_count(err0), .fail_vec(fv0)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(0), .ROUNDS(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef GATE_BIST_FAULT_INJ_EN
    .fault_inj(fi1),
`endif
    .start(start1), .a(a1), .b(b1), .y_in(y1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_mask(mask1), .err_count(err1), .fail_vec(fv1)
  );

  // Gate-under-test model; mode 1 = XOR output stuck at 0
  function automatic logic [7:0] gut(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ga | gb, ga & gb, ~(ga & gb), ~gb, ~ga};
  endfunction

  always_comb begin
    y0 = gut(a0, b0);
    if (mode0 == 1) y0[6] = 1'b0;
  end
  assign y1 = 8'h00;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Edge count since the accepted start edge (start edge = 0)
  always @(posedge clk) begin
    if (rst_n && start0 && !busy0) cyc0 <= 0; else cyc0 <= cyc0 + 1;
    if (rst_n && start1 && !busy1) cyc1 <= 0; else cyc1 <= cyc1 + 1;
  end

  // Monitor: pops expectations whenever a DUT presents done
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ab;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("dut0_pass", int'(pass0), int'(e.pass));
        chk("dut0_fail_mask", int'(mask0), int'(e.mask));
        chk("dut0_err_count", int'(err0), int'(e.err));
        chk("dut0_fail_vec", int'(fv0), int'(e.fv));
        chk("dut0_done_edge", cyc0, e.edge_n);
      end
    end
    if (busy0 && (qab.size() > 0) && ((cyc0 % 4) == 2)) begin
      ab = qab.pop_front();
      chk("dut0_ab_vector", int'({a0, b0}), int'(ab));
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("dut1_pass", int'(pass1), int'(e.pass));
        chk("dut1_fail_mask", int'(mask1), int'(e.mask));
        chk("dut1_err_count", int'(err1), int'(e.err));
        chk("dut1_fail_vec", int'(fv1), int'(e.fv));
        chk("dut1_done_edge", cyc1, e.edge_n);
      end
    end
  end

  task automatic push0(input logic p, input logic [7:0] m, input logic [3:0] er,
                       input logic [1:0] f, input int ed);
    exp_t e;
    e.pass = p; e.mask = m; e.err = er; e.fv = f; e.edge_n = ed;
    q0.push_back(e);
  endtask

  task automatic pulse_start0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_done0(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("dut0_done_seen", int'(seen), 1);
  endtask

  task automatic wait_done1(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    chk("dut1_done_seen", int'(seen), 1);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_ab"}, int'({a0, b0}), 0);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_done"}, int'(done0), 0);
    chk({tag, "_pass"}, int'(pass0), 0);
    chk({tag, "_fail_mask"}, int'(mask0), 0);
    chk({tag, "_err_count"}, int'(err0), 0);
    chk({tag, "_fail_vec"}, int'(fv0), 0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 chk_zero0("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Correct gate: sweep 00,01,10,11, pass at edge 16
    mode0 = 0;
    qab.push_back(2'b00); qab.push_back(2'b01); qab.push_back(2'b10); qab.push_back(2'b11);
    push0(1'b1, 8'h00, 4'd0, 2'b00, 16);
    pulse_start0();
    wait_done0(30);

    // XOR stuck at 0: mismatches at 01 and 10
    mode0 = 1;
    push0(1'b0, 8'h40, 4'd2, 2'b01, 16);
    pulse_start0();
    wait_done0(30);
    repeat (3) @(negedge clk);
    chk("hold_err_count", int'(err0), 2);
    chk("hold_fail_mask", int'(mask0), 8'h40);
    chk("hold_pass", int'(pass0), 0);

    // Reset during SETTLE of vector 10 aborts the run
    pulse_start0();
    chk("start_clears_mask", int'(mask0), 0);
    chk("start_clears_err", int'(err0), 0);
    repeat (9) @(negedge clk);
    chk("pre_reset_err", int'(err0), 1);
    chk("pre_reset_ab", int'({a0, b0}), 2);
    rst_n = 1'b0;
    #1 chk_zero0("midrun_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mode0 = 0;
    push0(1'b1, 8'h00, 4'd0, 2'b00, 16);
    pulse_start0();
    wait_done0(30);

    // start held high: one IDLE cycle between runs
    push0(1'b1, 8'h00, 4'd0, 2'b00, 16);
    push0(1'b1, 8'h00, 4'd0, 2'b00, 16);
    @(negedge clk) start0 = 1'b1;
    wait_done0(30);
    @(negedge clk);
    chk("held_start_idle_gap", int'(busy0), 0);
    @(negedge clk);
    chk("held_start_restart", int'(busy0), 1);
    wait_done0(30);
    start0 = 1'b0;
    repeat (3) @(negedge clk);

    // ROUNDS=5, SETTLE=0, y forced 0: saturation, done at edge 40
    begin
      exp_t e;
      e.pass = 1'b0; e.mask = 8'hFF; e.err = 4'd15; e.fv = 2'b00; e.edge_n = 40;
      q1.push_back(e);
    end
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_done1(60);

`ifdef GATE_BIST_FAULT_INJ_EN
    fi0 = 1'b1;
    push0(1'b0, 8'h04, 4'd4, 2'b00, 16);
    pulse_start0();
    wait_done0(30);
    fi0 = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("qab_drained", qab.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the wait cycles between driving a vector and sampling y_in (legal 0..15).
REQ-002 The block SHALL have parameter ROUNDS, default 1, giving the number of full 4-vector sweeps per run (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a run request sampled only in IDLE.
REQ-006 The block SHALL have ports a and b, output, 1 each, registered stimulus to the gate-under-test inputs.
REQ-007 The block SHALL have port y_in, input, 8, the gate-under-test outputs, indexed 0..7 as NOT a, NOT b, NAND, AND, OR, NOR, XOR, XNOR.
REQ-008 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at run end.
REQ-010 The block SHALL have port pass, output, 1, high when the last completed run had zero mismatches.
REQ-011 The block SHALL have port fail_mask, output, 8, a sticky per-bit mismatch flag for the current or last run.
REQ-012 The block SHALL have port err_count, output, 4, the count of CHECK cycles with any mismatch, saturating at 15.
REQ-013 The block SHALL have port fail_vec, output, 2, the {a,b} of the first mismatching vector, valid when pass=0 after done.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-015 In IDLE with start=1 the FSM SHALL go to DRIVE, clear fail_mask, err_count, fail_vec and pass, and reset the vector and round counters.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 DRIVE SHALL load {a,b} with the current vector in order 00, 01, 10, 11, with a as MSB.
REQ-018 DRIVE SHALL go to SETTLE for SETTLE_CYCLES cycles when SETTLE_CYCLES>0, and directly to CHECK when SETTLE_CYCLES=0.
REQ-019 a and b SHALL hold their value through SETTLE and CHECK, and SHALL be 0 in IDLE and DONE.
REQ-020 CHECK SHALL last one cycle and compare y_in against the expected vector computed from the registered a and b.
REQ-021 Each mismatching bit SHALL set its fail_mask bit.
REQ-022 Any mismatch SHALL increment err_count by 1, saturating at 15.
REQ-023 fail_vec SHALL be written only on the first mismatch of a run.
REQ-024 After CHECK the FSM SHALL advance to the next vector and go to DRIVE.
REQ-025 After vector 11 the FSM SHALL increment the round counter, and after the last round SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, set pass=(err_count==0 including this run's final CHECK), then return to IDLE.
REQ-027 With the start edge counted as edge 0, the FSM SHALL be in DONE exactly 4*ROUNDS*(SETTLE_CYCLES+2) edges later (16 at defaults).
REQ-028 pass, fail_mask, err_count and fail_vec SHALL hold after DONE until the next accepted start.

Reset
REQ-029 On rst_n=0 the block SHALL immediately, without a clock, enter IDLE with a, b, busy, done, pass, fail_mask, err_count, fail_vec and all counters at 0.
REQ-030 A reset mid-run SHALL abort the run, with no done pulse generated.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge with rst_n=1, and start SHALL be sampled from that edge.

Configuration
REQ-032 When GATE_BIST_FAULT_INJ_EN is defined, the block SHALL add input port fault_inj, 1 bit.
REQ-033 With GATE_BIST_FAULT_INJ_EN defined and fault_inj=1 during CHECK, the expected NAND bit (index 2) SHALL be inverted before comparison.
REQ-034 When GATE_BIST_FAULT_INJ_EN is undefined, the fault_inj port SHALL be absent and the expected values SHALL be unmodified.

Verification
REQ-035 Defaults, correct gate-under-test, start pulse -> a,b sequence 00,01,10,11; done 16 edges after start; pass=1, fail_mask=0x00, err_count=0.
REQ-036 y_in bit 6 (XOR) stuck at 0 -> mismatch at vectors 01 and 10; fail_mask=0x40, err_count=2, fail_vec=01, pass=0.
REQ-037 ROUNDS=5, SETTLE_CYCLES=0, y_in forced to 0x00 -> err_count saturates at 15 after 20 mismatching checks; done at edge 40.
REQ-038 rst_n pulsed low during SETTLE of vector 10 -> all outputs 0 at once, no done pulse; a fresh start gives a clean pass.
REQ-039 start held high throughout a run -> no restart while busy; a new run begins on the edge after DONE returns to IDLE.
REQ-040 GATE_BIST_FAULT_INJ_EN defined, fault_inj=1, correct gate-under-test -> fail_mask=0x04, err_count=4, fail_vec=00, pass=0.
